// File: rtl/jtopl_pkg.sv
// jtopl_pkg: shared constants and types for the OPL host-side write path.
// Holds chip settling waits, sequencer state encoding and request layout.
package jtopl_pkg;

  localparam int OPL_ADDR_WAIT = 12;
  localparam int OPL_DATA_WAIT = 84;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_AWAIT = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DWAIT = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_ADDR  = S_ADDR,
    ST_AWAIT = S_AWAIT,
    ST_DATA  = S_DATA,
    ST_DWAIT = S_DWAIT
  } wr_state_t;

  typedef struct packed {
    logic [7:0] rg;
    logic [7:0] val;
  } wr_req_t;

endpackage

// File: rtl/jtopl_wrfifo.sv
// jtopl_wrfifo: small synchronous FIFO with full/empty/occupancy.
// Ports: clk, rst (sync, high), push/din, pop/dout, full, empty, level.
module jtopl_wrfifo #(
  parameter int AW = 2,
  parameter int W  = 16
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign level = cnt;
  assign dout  = mem[rp];

  // full blocks a push even when a pop happens in the same cycle
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= din;
  end

endmodule

// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq: queues (reg, val) writes and replays them as OPL bus pairs.
// Ports: clk, rst, cen | in_valid/in_ready/in_reg/in_val |
//        bus_din/bus_addr/bus_write | busy, level.
module jtopl_wrseq
  import jtopl_pkg::*;
#(
  parameter int FIFO_AW   = 2,
  parameter int ADDR_WAIT = OPL_ADDR_WAIT,
  parameter int DATA_WAIT = OPL_DATA_WAIT,
  parameter int WAIT_W    = 7
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_reg,
  input  logic [7:0]       in_val,
  output logic [7:0]       bus_din,
  output logic             bus_addr,
  output logic             bus_write,
  output logic             busy,
  output logic [FIFO_AW:0] level
);

  wr_state_t   st;
  wr_state_t   st_n;
  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_n;

  wr_req_t     f_in;
  wr_req_t     f_head;
  logic        f_full;
  logic        f_empty;
  logic        pop;
  logic        push_ok;

  logic [7:0]  hold_reg;
  logic [7:0]  hold_val;
  logic [7:0]  cur_reg;
  logic        cur_ok;

  logic        ld_hold;
  logic        do_addr;
  logic        do_data;

  logic [7:0]  din_r;
  logic        addr_r;
  logic        wr_r;
  logic        busy_r;

  assign f_in     = '{rg: in_reg, val: in_val};
  assign in_ready = !f_full;
  assign push_ok  = in_valid && in_ready;

  jtopl_wrfifo #(
    .AW (FIFO_AW),
    .W  (16)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .din   (f_in),
    .pop   (pop),
    .dout  (f_head),
    .full  (f_full),
    .empty (f_empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= ST_IDLE;
      cnt <= '0;
    end else begin
      st  <= st_n;
      cnt <= cnt_n;
    end
  end

  always_comb begin
    st_n    = st;
    cnt_n   = cnt;
    pop     = 1'b0;
    ld_hold = 1'b0;
    do_addr = 1'b0;
    do_data = 1'b0;
    case (st)
      ST_IDLE: begin
        if (!f_empty) begin
          pop     = 1'b1;
          ld_hold = 1'b1;
          // register already selected on the chip: skip the address write
          if (cur_ok && cur_reg == f_head.rg) st_n = ST_DATA;
          else                                st_n = ST_ADDR;
        end
      end
      ST_ADDR: begin
        do_addr = 1'b1;
        cnt_n   = WAIT_W'(ADDR_WAIT);
        st_n    = ST_AWAIT;
      end
      ST_AWAIT: begin
        if (cnt == '0) st_n  = ST_DATA;
        else if (cen)  cnt_n = cnt - 1'b1;
      end
      ST_DATA: begin
        do_data = 1'b1;
        cnt_n   = WAIT_W'(DATA_WAIT);
        st_n    = ST_DWAIT;
      end
      ST_DWAIT: begin
        if (cnt == '0) st_n  = ST_IDLE;
        else if (cen)  cnt_n = cnt - 1'b1;
      end
      default: st_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg <= '0;
      hold_val <= '0;
      cur_reg  <= '0;
      cur_ok   <= 1'b0;
      din_r    <= '0;
      addr_r   <= 1'b0;
      wr_r     <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (ld_hold) begin
        hold_reg <= f_head.rg;
        hold_val <= f_head.val;
      end
      wr_r <= do_addr || do_data;
      if (do_addr) begin
        din_r   <= hold_reg;
        addr_r  <= 1'b0;
        cur_reg <= hold_reg;
        cur_ok  <= 1'b1;
      end
      if (do_data) begin
        din_r  <= hold_val;
        addr_r <= 1'b1;
      end
      busy_r <= (st_n != ST_IDLE) || !f_empty || push_ok;
    end
  end

  assign bus_din   = din_r;
  assign bus_addr  = addr_r;
  // a strobe latched just before reset must not reach the chip
  assign bus_write = wr_r && !rst;
  assign busy      = busy_r;

endmodule

// File: tb/tb_jtopl_wrseq.sv
// tb_jtopl_wrseq: directed bench for the OPL write sequencer.
// u0 uses default waits, uz uses zero waits.
module tb_jtopl_wrseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;

  logic       in_valid = 1'b0;
  logic [7:0] in_reg = '0;
  logic [7:0] in_val = '0;
  logic       in_ready;
  logic [7:0] bus_din;
  logic       bus_addr;
  logic       bus_write;
  logic       busy;
  logic [2:0] level;

  logic       z_valid = 1'b0;
  logic [7:0] z_reg = '0;
  logic [7:0] z_val = '0;
  logic       z_ready;
  logic [7:0] z_din;
  logic       z_addr;
  logic       z_write;
  logic       z_busy;
  logic [2:0] z_level;

  int n_pass = 0;
  int n_tot  = 0;

  logic [8:0] cap [12];
  int         ncap;

  always #5 clk = ~clk;

  jtopl_wrseq u0 (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_reg    (in_reg),
    .in_val    (in_val),
    .bus_din   (bus_din),
    .bus_addr  (bus_addr),
    .bus_write (bus_write),
    .busy      (busy),
    .level     (level)
  );

  jtopl_wrseq #(
    .ADDR_WAIT (0),
    .DATA_WAIT (0)
  ) uz (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .in_valid  (z_valid),
    .in_ready  (z_ready),
    .in_reg    (z_reg),
    .in_val    (z_val),
    .bus_din   (z_din),
    .bus_addr  (z_addr),
    .bus_write (z_write),
    .busy      (z_busy),
    .level     (z_level)
  );

  task automatic push(input logic [7:0] r, input logic [7:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_reg   = r;
    in_val   = v;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (bus_write) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (!busy) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic capture(input int n, input int maxc);
    ncap = 0;
    for (int i = 0; i < maxc && ncap < n; i++) begin
      @(negedge clk);
      if (bus_write) begin
        cap[ncap] = {bus_addr, bus_din};
        ncap++;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cen = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tot++;
    if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready);
    else n_pass++;
    n_tot++;
    if (bus_din !== 8'h00) $display("FAIL rst_din: got %h want 00", bus_din);
    else n_pass++;
    n_tot++;
    if (bus_addr !== 1'b0) $display("FAIL rst_addr: got %b want 0", bus_addr);
    else n_pass++;
    n_tot++;
    if (bus_write !== 1'b0) $display("FAIL rst_write: got %b want 0", bus_write);
    else n_pass++;
    n_tot++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy);
    else n_pass++;
    n_tot++;
    if (level !== 3'd0) $display("FAIL rst_level: got %0d want 0", level);
    else n_pass++;
  endtask

  task automatic test_single;
    int k;
    cen = 1'b1;
    push(8'hBD, 8'hC0);
    n_tot++;
    if (busy !== 1'b1 || level !== 3'd1)
      $display("FAIL single_accept: busy %b level %0d want 1 1", busy, level);
    else n_pass++;
    wait_strobe(10, k);
    n_tot++;
    if (k !== 2) $display("FAIL single_latency: got %0d want 2", k);
    else n_pass++;
    n_tot++;
    if (bus_addr !== 1'b0 || bus_din !== 8'hBD)
      $display("FAIL single_addr: got %b/%h want 0/bd", bus_addr, bus_din);
    else n_pass++;
    wait_strobe(40, k);
    n_tot++;
    if (k !== 14) $display("FAIL single_agap: got %0d want 14", k);
    else n_pass++;
    n_tot++;
    if (bus_addr !== 1'b1 || bus_din !== 8'hC0)
      $display("FAIL single_data: got %b/%h want 1/c0", bus_addr, bus_din);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (bus_write !== 1'b0 || bus_din !== 8'hC0 || bus_addr !== 1'b1)
      $display("FAIL single_hold: got w%b %b/%h want w0 1/c0",
               bus_write, bus_addr, bus_din);
    else n_pass++;
    wait_idle(200, k);
    n_tot++;
    if (k !== 84) $display("FAIL single_dwait: got %0d want 84", k);
    else n_pass++;
  endtask

  task automatic test_cache;
    int k;
    cen = 1'b1;
    push(8'hA0, 8'h41);
    push(8'hA0, 8'h42);
    wait_strobe(10, k);
    n_tot++;
    if (k < 0 || bus_addr !== 1'b0 || bus_din !== 8'hA0)
      $display("FAIL cache_addr: got k%0d %b/%h want 0/a0", k, bus_addr, bus_din);
    else n_pass++;
    wait_strobe(40, k);
    n_tot++;
    if (k !== 14 || bus_addr !== 1'b1 || bus_din !== 8'h41)
      $display("FAIL cache_data1: got k%0d %b/%h want k14 1/41",
               k, bus_addr, bus_din);
    else n_pass++;
    wait_strobe(200, k);
    n_tot++;
    if (k !== 87 || bus_addr !== 1'b1 || bus_din !== 8'h42)
      $display("FAIL cache_data2: got k%0d %b/%h want k87 1/42",
               k, bus_addr, bus_din);
    else n_pass++;
    wait_idle(200, k);
    n_tot++;
    if (k !== 85) $display("FAIL cache_idle: got %0d want 85", k);
    else n_pass++;
  endtask

  task automatic test_fill;
    int k;
    logic [8:0] exp_t [11];
    exp_t = '{9'h106, 9'h010, 9'h101, 9'h011, 9'h102, 9'h012,
              9'h103, 9'h013, 9'h104, 9'h014, 9'h105};
    cen = 1'b0;
    push(8'h15, 8'h06);
    wait_strobe(10, k);
    push(8'h10, 8'h01);
    push(8'h11, 8'h02);
    push(8'h12, 8'h03);
    push(8'h13, 8'h04);
    n_tot++;
    if (in_ready !== 1'b0 || level !== 3'd4)
      $display("FAIL fill_full: ready %b level %0d want 0 4", in_ready, level);
    else n_pass++;
    in_valid = 1'b1;
    in_reg   = 8'h14;
    in_val   = 8'h05;
    repeat (3) @(negedge clk);
    n_tot++;
    if (level !== 3'd4 || in_ready !== 1'b0)
      $display("FAIL fill_stall: level %0d ready %b want 4 0", level, in_ready);
    else n_pass++;
    cen = 1'b1;
    fork
      begin
        int n;
        n = 0;
        while (!in_ready && n < 3000) begin
          @(negedge clk);
          n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      capture(11, 3000);
    join
    n_tot++;
    if (ncap !== 11) $display("FAIL fill_count: got %0d want 11", ncap);
    else n_pass++;
    for (int i = 0; i < 11; i++) begin
      n_tot++;
      if (cap[i] !== exp_t[i])
        $display("FAIL fill_seq%0d: got %h want %h", i, cap[i], exp_t[i]);
      else n_pass++;
    end
    wait_idle(300, k);
    n_tot++;
    if (busy !== 1'b0 || level !== 3'd0)
      $display("FAIL fill_drain: busy %b level %0d want 0 0", busy, level);
    else n_pass++;
  endtask

  task automatic test_slow_cen;
    int k;
    int g;
    cen = 1'b0;
    push(8'h30, 8'h55);
    wait_strobe(10, k);
    n_tot++;
    if (k < 0 || bus_addr !== 1'b0 || bus_din !== 8'h30)
      $display("FAIL slow_addr: got k%0d %b/%h want 0/30", k, bus_addr, bus_din);
    else n_pass++;
    g = -1;
    for (int i = 1; i <= 200; i++) begin
      cen = (i % 4 == 0);
      @(negedge clk);
      if (bus_write) begin
        g = i;
        break;
      end
    end
    n_tot++;
    if (g - 1 !== 49) $display("FAIL slow_gap: got %0d want 49", g - 1);
    else n_pass++;
    n_tot++;
    if (bus_addr !== 1'b1 || bus_din !== 8'h55)
      $display("FAIL slow_data: got %b/%h want 1/55", bus_addr, bus_din);
    else n_pass++;
    cen = 1'b1;
    wait_idle(400, k);
    n_tot++;
    if (busy !== 1'b0) $display("FAIL slow_idle: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int k;
    int ns;
    cen = 1'b1;
    push(8'h20, 8'h01);
    wait_strobe(10, k);
    n_tot++;
    if (k < 0 || bus_addr !== 1'b0 || bus_din !== 8'h20)
      $display("FAIL rmid_addr: got k%0d %b/%h want 0/20", k, bus_addr, bus_din);
    else n_pass++;
    push(8'h21, 8'h07);
    n_tot++;
    if (level !== 3'd1) $display("FAIL rmid_queued: got %0d want 1", level);
    else n_pass++;
    rst = 1'b1;
    n_tot++;
    if (bus_write !== 1'b0) $display("FAIL rmid_rstcyc: got %b want 0", bus_write);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    ns = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus_write) ns++;
    end
    n_tot++;
    if (ns !== 0) $display("FAIL rmid_nostrobe: got %0d want 0", ns);
    else n_pass++;
    n_tot++;
    if (level !== 3'd0 || busy !== 1'b0)
      $display("FAIL rmid_flush: level %0d busy %b want 0 0", level, busy);
    else n_pass++;
    push(8'h20, 8'h02);
    wait_strobe(10, k);
    n_tot++;
    if (k !== 2 || bus_addr !== 1'b0 || bus_din !== 8'h20)
      $display("FAIL rmid_reissue: got k%0d %b/%h want k2 0/20",
               k, bus_addr, bus_din);
    else n_pass++;
    wait_idle(300, k);
    n_tot++;
    if (busy !== 1'b0) $display("FAIL rmid_idle: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_zero_wait;
    logic [8:0] zc [4];
    int         zt [4];
    int         n;
    cen = 1'b0;
    z_valid = 1'b1;
    z_reg   = 8'h40;
    z_val   = 8'h11;
    @(negedge clk);
    z_reg   = 8'h41;
    z_val   = 8'h22;
    @(negedge clk);
    z_valid = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && n < 4; i++) begin
      @(negedge clk);
      if (z_write) begin
        zc[n] = {z_addr, z_din};
        zt[n] = i;
        n++;
      end
    end
    n_tot++;
    if (n !== 4) $display("FAIL zero_count: got %0d want 4", n);
    else n_pass++;
    if (n == 4) begin
      n_tot++;
      if (zt[0] !== 1) $display("FAIL zero_latency: got %0d want 1", zt[0]);
      else n_pass++;
      n_tot++;
      if (zc[0] !== 9'h040 || zc[1] !== 9'h111)
        $display("FAIL zero_pair1: got %h %h want 040 111", zc[0], zc[1]);
      else n_pass++;
      n_tot++;
      if (zc[2] !== 9'h041 || zc[3] !== 9'h122)
        $display("FAIL zero_pair2: got %h %h want 041 122", zc[2], zc[3]);
      else n_pass++;
      n_tot++;
      if (zt[1] - zt[0] !== 2 || zt[3] - zt[2] !== 2)
        $display("FAIL zero_gap: got %0d %0d want 2 2",
                 zt[1] - zt[0], zt[3] - zt[2]);
      else n_pass++;
      n_tot++;
      if (zt[2] - zt[1] < 2)
        $display("FAIL zero_adjacent: got %0d want >=2", zt[2] - zt[1]);
      else n_pass++;
    end
    repeat (4) @(negedge clk);
    n_tot++;
    if (z_busy !== 1'b0 || z_level !== 3'd0)
      $display("FAIL zero_idle: busy %b level %0d want 0 0", z_busy, z_level);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_cache;
    test_fill;
    test_slow_cen;
    test_reset_mid;
    test_zero_wait;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
